// File: rtl/serial_adder_arbiter_pkg.sv
// Shared types and helpers for the serial adder arbiter.
// Imported by the top and by the round-robin picker.
package serial_adder_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2
  } arb_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_adder_arbiter_picker.sv
// Round-robin one-hot picker: rotate by pointer,
// isolate lowest set bit, rotate back.
module rr_priority_picker
  import serial_adder_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  pick_o
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] rot;
  logic [N-1:0] low;

  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++)
      rot[i] = req_i[(i + int'(ptr_i)) % N];
    low = rot & (~rot + ONE);
    pick_o = '0;
    for (int i = 0; i < N; i++)
      pick_o[(i + int'(ptr_i)) % N] = low[i];
  end

endmodule

// File: rtl/serial_adder_arbiter.sv
// Round-robin arbiter sharing one serial adder core
// among NUM_CH serial requesters, one word at a time.
module serial_adder_arbiter
  import serial_adder_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [NUM_CH-1:0] iv_req,
  input  logic [NUM_CH-1:0] iv_din_a,
  input  logic [NUM_CH-1:0] iv_din_b,
  input  logic [NUM_CH-1:0] iv_valid,
  output logic [NUM_CH-1:0] ov_ready,
  output logic [NUM_CH-1:0] ov_sum,
  output logic [NUM_CH-1:0] ov_valid,
  input  logic [NUM_CH-1:0] iv_ready,
  output logic              o_add_din_a,
  output logic              o_add_din_b,
  output logic              o_add_valid,
  input  logic              i_add_ready,
  input  logic              i_add_sum,
  input  logic              i_add_valid,
  output logic              o_add_ready,
  output logic [NUM_CH-1:0] ov_grant,
  output logic              o_busy,
  output logic              o_err
);

  localparam int BW = clog2(DATA_WIDTH);
  localparam int TW = clog2(TIMEOUT + 1);
  localparam int PW = clog2(NUM_CH);
  localparam logic [BW-1:0] BEAT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(NUM_CH - 1);

  arb_state_e        state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [NUM_CH-1:0] pick;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     own;
  logic [BW-1:0]     beat_q, beat_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              in_send, in_recv;
  logic              send, recv;
  logic              tx_beat, rx_beat;
  logic              word_done, tmo_hit;

  rr_priority_picker #(
    .N (NUM_CH),
    .PW(PW)
  ) u_pick (
    .req_i (iv_req),
    .ptr_i (ptr_q),
    .pick_o(pick)
  );

  always_comb begin
    own = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (grant_q[i]) own = PW'(i);
  end

  assign in_send = (state_q == SEND);
  assign in_recv = (state_q == RECV);
  assign send    = i_en && in_send;
  assign recv    = i_en && in_recv;

  assign o_add_din_a = in_send && |(iv_din_a & grant_q);
  assign o_add_din_b = in_send && |(iv_din_b & grant_q);
  assign o_add_valid = send && |(iv_valid & grant_q);
  assign ov_ready    = grant_q & {NUM_CH{send && i_add_ready}};
  assign o_add_ready = recv && |(iv_ready & grant_q);
  assign ov_valid    = grant_q & {NUM_CH{recv && i_add_valid}};
  assign ov_sum      = grant_q & {NUM_CH{in_recv && i_add_sum}};

  assign tx_beat   = o_add_valid && i_add_ready;
  assign rx_beat   = i_add_valid && o_add_ready;
  assign word_done = (beat_q == BEAT_LAST);
  assign tmo_hit   = (tmo_q == TMO_LAST);

  // A final result beat landing on the timeout cycle wins.
  assign o_err    = recv && tmo_hit && !(rx_beat && word_done);
  assign ov_grant = grant_q;
  assign o_busy   = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    tmo_d   = tmo_q;
    if (i_en) begin
      unique case (state_q)
        IDLE: begin
          if (|iv_req) begin
            grant_d = pick;
            state_d = SEND;
            beat_d  = '0;
            tmo_d   = '0;
          end
        end
        SEND: begin
          if (tx_beat) begin
            if (word_done) begin
              state_d = RECV;
              beat_d  = '0;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
        RECV: begin
          if ((rx_beat && word_done) || tmo_hit) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = (own == PTR_LAST) ? '0 : own + 1'b1;
            beat_d  = '0;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
            if (rx_beat) beat_d = beat_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule
